// File: rtl/dds_sweep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dds_sweep_ctrl
//  Description : Frequency-sweep sequencer for a DDS core. Holds a shadow copy
//                of the sweep configuration and steps the frequency word from
//                f_start toward f_stop, holding each word for a programmable
//                dwell. Steps that would overshoot f_stop or leave the 32-bit
//                range land exactly on f_stop. Supports one-shot and
//                continuous modes plus an immediate abort.
//  Revision    : 1.0 - initial release
// ============================================================================
module dds_sweep_ctrl #(
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [31:0]        cfg_f_start,
  input  logic [31:0]        cfg_f_stop,
  input  logic [31:0]        cfg_f_step,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic               cfg_mode,
  input  logic [11:0]        cfg_pword,
  input  logic               start,
  input  logic               abort,
  output logic [31:0]        fword,
  output logic [11:0]        pword,
  output logic               upd,
  output logic               busy,
  output logic               done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DWELL = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [DWELL_W-1:0] DWELL_ONE = {{(DWELL_W-1){1'b0}}, 1'b1};

  logic [1:0]         state_q, state_d;

  // Shadow configuration
  logic [31:0]        f_start_q, f_start_d;
  logic [31:0]        f_stop_q, f_stop_d;
  logic [31:0]        f_step_q, f_step_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               mode_q, mode_d;
  logic [11:0]        pword_cfg_q, pword_cfg_d;
  logic               cfg_loaded_q, cfg_loaded_d;

  // Sweep datapath
  logic [31:0]        fword_q, fword_d;
  logic [11:0]        pword_q, pword_d;
  logic               upd_q, upd_d;
  logic               dir_up_q, dir_up_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;

  logic               cfg_hs;
  logic               start_ok;
  logic               expiry;
  logic               at_stop;
  logic [DWELL_W-1:0] reload;
  logic [32:0]        sum33;
  logic [32:0]        diff33;
  logic [31:0]        next_f;

  assign cfg_hs   = cfg_valid && (state_q == S_IDLE);
  // Abort beats start; a start without a loaded configuration is dropped.
  assign start_ok = start && !abort && (state_q == S_IDLE) && cfg_loaded_q;
  assign expiry   = (state_q == S_DWELL) && (cnt_q == '0);
  assign at_stop  = (fword_q == f_stop_q);
  // A dwell of zero is treated as one cycle; the counter counts down to zero.
  assign reload   = (dwell_d == '0) ? '0 : (dwell_d - DWELL_ONE);

  // Next frequency word: 33-bit add/subtract so carry/borrow is visible, then
  // clamp onto f_stop on overshoot, wrap, or a zero step.
  always_comb begin
    sum33  = {1'b0, fword_q} + {1'b0, f_step_q};
    diff33 = {1'b0, fword_q} - {1'b0, f_step_q};
    next_f = f_stop_q;
    if (dir_up_q) begin
      if ((f_step_q != '0) && !sum33[32] && (sum33[31:0] <= f_stop_q))
        next_f = sum33[31:0];
    end else begin
      if ((f_step_q != '0) && !diff33[32] && (diff33[31:0] >= f_stop_q))
        next_f = diff33[31:0];
    end
  end

  // Shadow configuration capture; only possible in IDLE, so constant while busy.
  always_comb begin
    f_start_d    = f_start_q;
    f_stop_d     = f_stop_q;
    f_step_d     = f_step_q;
    dwell_d      = dwell_q;
    mode_d       = mode_q;
    pword_cfg_d  = pword_cfg_q;
    cfg_loaded_d = cfg_loaded_q;
    if (cfg_hs) begin
      f_start_d    = cfg_f_start;
      f_stop_d     = cfg_f_stop;
      f_step_d     = cfg_f_step;
      dwell_d      = cfg_dwell;
      mode_d       = cfg_mode;
      pword_cfg_d  = cfg_pword;
      cfg_loaded_d = 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; abort forces IDLE from any state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_ok) state_d = S_DWELL;
      S_DWELL: if (expiry && at_stop && !mode_q) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
  end

  // Datapath next values: load on start, count dwell, step or wrap on expiry.
  always_comb begin
    fword_d  = fword_q;
    pword_d  = pword_q;
    upd_d    = 1'b0;
    dir_up_d = dir_up_q;
    cnt_d    = cnt_q;
    if (start_ok) begin
      fword_d  = f_start_d;
      pword_d  = pword_cfg_d;
      upd_d    = 1'b1;
      cnt_d    = reload;
      dir_up_d = (f_stop_d >= f_start_d);
    end else if ((state_q == S_DWELL) && !abort) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - DWELL_ONE;
      end else if (!at_stop) begin
        fword_d = next_f;
        upd_d   = 1'b1;
        cnt_d   = reload;
      end else if (mode_q) begin
        fword_d = f_start_q;
        upd_d   = 1'b1;
        cnt_d   = reload;
      end
    end
  end

  // Datapath and shadow registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      f_start_q    <= '0;
      f_stop_q     <= '0;
      f_step_q     <= '0;
      dwell_q      <= '0;
      mode_q       <= 1'b0;
      pword_cfg_q  <= '0;
      cfg_loaded_q <= 1'b0;
      fword_q      <= '0;
      pword_q      <= '0;
      upd_q        <= 1'b0;
      dir_up_q     <= 1'b0;
      cnt_q        <= '0;
    end else begin
      f_start_q    <= f_start_d;
      f_stop_q     <= f_stop_d;
      f_step_q     <= f_step_d;
      dwell_q      <= dwell_d;
      mode_q       <= mode_d;
      pword_cfg_q  <= pword_cfg_d;
      cfg_loaded_q <= cfg_loaded_d;
      fword_q      <= fword_d;
      pword_q      <= pword_d;
      upd_q        <= upd_d;
      dir_up_q     <= dir_up_d;
      cnt_q        <= cnt_d;
    end
  end

  // Output decode from state and registers
  always_comb begin
    cfg_ready = (state_q == S_IDLE);
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    fword     = fword_q;
    pword     = pword_q;
    upd       = upd_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_dds_sweep_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_dds_sweep_ctrl
//  Description : Self-checking bench for dds_sweep_ctrl: directed vector
//                table, hand-written corner sequences and randomized sweeps
//                checked against a plain-arithmetic sweep model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dds_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [31:0] cfg_f_start, cfg_f_stop, cfg_f_step;
  logic [15:0] cfg_dwell;
  logic        cfg_mode;
  logic [11:0] cfg_pword;
  logic        start, abort;
  logic [31:0] fword;
  logic [11:0] pword;
  logic        upd, busy, done;

  int passed = 0;
  int total  = 0;
  logic [31:0] exp_q [$];
  logic [11:0] cur_pw;

  dds_sweep_ctrl #(.DWELL_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_f_start(cfg_f_start), .cfg_f_stop(cfg_f_stop), .cfg_f_step(cfg_f_step),
    .cfg_dwell(cfg_dwell), .cfg_mode(cfg_mode), .cfg_pword(cfg_pword),
    .start(start), .abort(abort),
    .fword(fword), .pword(pword), .upd(upd), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [31:0] fs;
    logic [31:0] fe;
    logic [31:0] st;
    logic [15:0] dw;
    logic        mode;
    logic [11:0] pw;
    logic [3:0]  laps;
    logic [3:0]  abidx;
    logic [3:0]  n;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [31:0] e2;
    logic [31:0] e3;
  } vec_t;

  vec_t vecs [8];

  function automatic vec_t mk(input logic [31:0] fs, fe, st, input logic [15:0] dw,
                              input logic mode, input logic [11:0] pw,
                              input logic [3:0] laps, abidx, n,
                              input logic [31:0] e0, e1, e2, e3);
    vec_t v;
    v.fs = fs; v.fe = fe; v.st = st; v.dw = dw; v.mode = mode; v.pw = pw;
    v.laps = laps; v.abidx = abidx; v.n = n;
    v.e0 = e0; v.e1 = e1; v.e2 = e2; v.e3 = e3;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act === expv) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
  endtask

  // Per-cycle check while a frequency word is being held.
  task automatic chk_cycle(input logic [31:0] f, input logic first);
    chk("fword", fword, f);
    chk("pword", {20'd0, pword}, {20'd0, cur_pw});
    chk("upd", {31'd0, upd}, {31'd0, first});
    chk("busy", {31'd0, busy}, 32'd1);
    chk("done_low", {31'd0, done}, 32'd0);
    chk("cfg_ready_busy", {31'd0, cfg_ready}, 32'd0);
  endtask

  // Reference sweep: list of frequency words for one pass from fs to fe.
  task automatic model_seq(input logic [31:0] fs, input logic [31:0] fe, input logic [31:0] st);
    longint unsigned v, nv, s, e, stp;
    int guard;
    s = {32'd0, fs}; e = {32'd0, fe}; stp = {32'd0, st};
    exp_q.delete();
    v = s;
    exp_q.push_back(fs);
    guard = 0;
    while (v != e && guard < 64) begin
      if (e >= s) begin
        nv = v + stp;
        if (stp == 0 || nv > e) nv = e;
      end else begin
        if (stp == 0 || stp > v || (v - stp) < e) nv = e;
        else nv = v - stp;
      end
      v = nv;
      exp_q.push_back(v[31:0]);
      guard++;
    end
  endtask

  // Load config, start, and check the whole sweep against exp_q.
  task automatic run_sweep(input logic [31:0] fs, fe, st, input logic [15:0] dw,
                           input logic mode, input logic [11:0] pw,
                           input int laps, input int abidx);
    int d, n;
    d = (dw == 16'd0) ? 1 : int'(dw);
    n = exp_q.size();
    cur_pw = pw;
    cfg_f_start = fs; cfg_f_stop = fe; cfg_f_step = st;
    cfg_dwell = dw; cfg_mode = mode; cfg_pword = pw; cfg_valid = 1'b1;
    chk("cfg_ready_idle", {31'd0, cfg_ready}, 32'd1);
    tick();
    cfg_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    // Offer junk configuration throughout the sweep; it must not be taken.
    cfg_valid = 1'b1;
    cfg_f_start = $urandom; cfg_f_stop = $urandom; cfg_f_step = $urandom;
    cfg_dwell = 16'($urandom_range(0, 7)); cfg_mode = 1'($urandom); cfg_pword = 12'($urandom);
    for (int lap = 0; lap < laps; lap++)
      for (int i = 0; i < n; i++)
        for (int k = 0; k < d; k++) begin
          chk_cycle(exp_q[i], k == 0);
          tick();
        end
    if (!mode) begin
      chk("done_pulse", {31'd0, done}, 32'd1);
      chk("busy_in_done", {31'd0, busy}, 32'd1);
      chk("upd_in_done", {31'd0, upd}, 32'd0);
      chk("fword_in_done", fword, exp_q[n-1]);
      tick();
      chk("busy_after_done", {31'd0, busy}, 32'd0);
      chk("done_after_done", {31'd0, done}, 32'd0);
      chk("fword_hold_idle", fword, exp_q[n-1]);
      chk("pword_hold_idle", {20'd0, pword}, {20'd0, pw});
    end else begin
      for (int i = 0; i < abidx; i++)
        for (int k = 0; k < d; k++) begin
          chk_cycle(exp_q[i], k == 0);
          tick();
        end
      chk("fword_before_abort", fword, exp_q[abidx]);
      chk("upd_before_abort", {31'd0, upd}, 32'd1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("busy_after_abort", {31'd0, busy}, 32'd0);
      chk("done_after_abort", {31'd0, done}, 32'd0);
      chk("upd_after_abort", {31'd0, upd}, 32'd0);
      chk("fword_hold_abort", fword, exp_q[abidx]);
    end
    cfg_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] rfs, rfe, rst;
    logic [15:0] rdw;
    logic        rmode;
    longint unsigned span;
    int r;

    rst_n = 1'b0; cfg_valid = 1'b0; start = 1'b0; abort = 1'b0;
    cfg_f_start = '0; cfg_f_stop = '0; cfg_f_step = '0;
    cfg_dwell = '0; cfg_mode = 1'b0; cfg_pword = '0; cur_pw = '0;

    vecs[0] = mk(32'd100, 32'd130, 32'd10, 16'd3, 1'b0, 12'h5A5, 4'd1, 4'd0, 4'd4,
                 32'd100, 32'd110, 32'd120, 32'd130);
    vecs[1] = mk(32'd100, 32'd130, 32'd25, 16'd1, 1'b0, 12'h123, 4'd1, 4'd0, 4'd3,
                 32'd100, 32'd125, 32'd130, 32'd0);
    vecs[2] = mk(32'd130, 32'd100, 32'd20, 16'd2, 1'b0, 12'hABC, 4'd1, 4'd0, 4'd3,
                 32'd130, 32'd110, 32'd100, 32'd0);
    vecs[3] = mk(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 16'd1, 1'b0, 12'h001, 4'd1, 4'd0, 4'd2,
                 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'd0, 32'd0);
    vecs[4] = mk(32'd50, 32'd80, 32'd0, 16'd0, 1'b0, 12'hFFF, 4'd1, 4'd0, 4'd2,
                 32'd50, 32'd80, 32'd0, 32'd0);
    vecs[5] = mk(32'd30, 32'd5, 32'd50, 16'd2, 1'b0, 12'h777, 4'd1, 4'd0, 4'd2,
                 32'd30, 32'd5, 32'd0, 32'd0);
    vecs[6] = mk(32'd0, 32'd20, 32'd10, 16'd1, 1'b1, 12'h246, 4'd1, 4'd1, 4'd3,
                 32'd0, 32'd10, 32'd20, 32'd0);
    vecs[7] = mk(32'd7, 32'd7, 32'd3, 16'd2, 1'b0, 12'h0F0, 4'd1, 4'd0, 4'd1,
                 32'd7, 32'd0, 32'd0, 32'd0);

    // Reset state
    tick(); tick();
    chk("rst_fword", fword, 32'd0);
    chk("rst_pword", {20'd0, pword}, 32'd0);
    chk("rst_upd", {31'd0, upd}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_cfg_ready", {31'd0, cfg_ready}, 32'd1);
    rst_n = 1'b1;
    tick();

    // Start before any configuration is ignored
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("nocfg_busy", {31'd0, busy}, 32'd0);
    chk("nocfg_upd", {31'd0, upd}, 32'd0);
    tick();
    chk("nocfg_busy2", {31'd0, busy}, 32'd0);

    // Directed vector table
    for (int v = 0; v < 8; v++) begin
      exp_q.delete();
      exp_q.push_back(vecs[v].e0);
      if (vecs[v].n > 4'd1) exp_q.push_back(vecs[v].e1);
      if (vecs[v].n > 4'd2) exp_q.push_back(vecs[v].e2);
      if (vecs[v].n > 4'd3) exp_q.push_back(vecs[v].e3);
      run_sweep(vecs[v].fs, vecs[v].fe, vecs[v].st, vecs[v].dw, vecs[v].mode,
                vecs[v].pw, int'(vecs[v].laps), int'(vecs[v].abidx));
      tick();
    end

    // abort and start in the same IDLE cycle (config is loaded at this point)
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("abort_start_busy", {31'd0, busy}, 32'd0);
    chk("abort_start_upd", {31'd0, upd}, 32'd0);
    tick();
    chk("abort_start_busy2", {31'd0, busy}, 32'd0);

    // Reset in the middle of a sweep
    cfg_f_start = 32'd100; cfg_f_stop = 32'd130; cfg_f_step = 32'd10;
    cfg_dwell = 16'd3; cfg_mode = 1'b0; cfg_pword = 12'h321; cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    chk("mid_fword_pre_rst", fword, 32'd110);
    rst_n = 1'b0;
    tick();
    chk("midrst_fword", fword, 32'd0);
    chk("midrst_pword", {20'd0, pword}, 32'd0);
    chk("midrst_upd", {31'd0, upd}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("midrst_cfg_ready", {31'd0, cfg_ready}, 32'd1);
    chk("midrst_no_done", {31'd0, done}, 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("midrst_start_ignored", {31'd0, busy}, 32'd0);

    // Randomized sweeps against the reference model
    for (int it = 0; it < 30; it++) begin
      rfs = $urandom;
      r = $urandom_range(0, 9);
      rfe = (r == 9) ? 32'hFFFF_FFFF : ((r == 8) ? 32'd0 : $urandom);
      span = (rfe >= rfs) ? longint'(rfe - rfs) : longint'(rfs - rfe);
      r = $urandom_range(0, 9);
      if (r == 0)      rst = 32'd0;
      else if (r == 1) rst = $urandom;
      else             rst = 32'(span / longint'($urandom_range(1, 8))) + 32'($urandom_range(0, 5));
      if (rst != 0 && rst < 32'(span / 9)) rst = 32'(span / 9) + 32'd1;
      rdw = 16'($urandom_range(0, 4));
      rmode = ($urandom_range(0, 3) == 0);
      model_seq(rfs, rfe, rst);
      run_sweep(rfs, rfe, rst, rdw, rmode, 12'($urandom), rmode ? 2 : 1,
                rmode ? int'($urandom_range(0, exp_q.size() - 1)) : 0);
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dds_sweep_ctrl.md
DDS_SWEEP_CTRL -- requirements
Module: dds_sweep_ctrl

Interface
REQ-001 SHALL have parameter DWELL_W, default 16, width of the dwell-count field.
REQ-002 SHALL have port clk  in  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port cfg_valid  in  1  configuration offered.
REQ-005 SHALL have port cfg_ready  out  1  configuration accepted when cfg_valid && cfg_ready.
REQ-006 SHALL have port cfg_f_start  in  32  first frequency word.
REQ-007 SHALL have port cfg_f_stop  in  32  last frequency word.
REQ-008 SHALL have port cfg_f_step  in  32  unsigned step magnitude.
REQ-009 SHALL have port cfg_dwell  in  DWELL_W  clocks each frequency word is held; 0 treated as 1.
REQ-010 SHALL have port cfg_mode  in  1  0 = one-shot, 1 = continuous.
REQ-011 SHALL have port cfg_pword  in  12  phase word applied for the whole sweep.
REQ-012 SHALL have port start  in  1  single-cycle sweep request.
REQ-013 SHALL have port abort  in  1  stop sweep immediately.
REQ-014 SHALL have port fword  out  32  frequency word to the DDS core.
REQ-015 SHALL have port pword  out  12  phase word to the DDS core.
REQ-016 SHALL have port upd  out  1  one-cycle pulse in the first cycle a new fword/pword value is driven.
REQ-017 SHALL have port busy  out  1  high whenever the state is not IDLE.
REQ-018 SHALL have port done  out  1  one-cycle pulse at one-shot sweep completion.

Function
REQ-019 SHALL implement states IDLE, DWELL, DONE.
REQ-020 SHALL assert cfg_ready only in IDLE; SHALL capture all cfg_* into shadow registers on handshake and set a cfg_loaded flag.
REQ-021 SHALL ignore start unless state = IDLE and cfg_loaded = 1.
REQ-022 On an accepted start in cycle N: fword = f_start, pword = cfg_pword, upd = 1 and state = DWELL in cycle N+1.
REQ-023 Direction SHALL be up if f_stop >= f_start, otherwise down, fixed at start.
REQ-024 Each fword value SHALL be held exactly max(dwell,1) cycles via a down-counter reloaded on every fword update.
REQ-025 At dwell expiry with fword != f_stop: next = fword ± step computed 33-bit; SHALL clamp to f_stop if it passes f_stop or carries/borrows; no 32-bit wrap; upd = 1.
REQ-026 step = 0 SHALL make the next value f_stop.
REQ-027 At dwell expiry with fword == f_stop: one-shot -> DONE; continuous -> fword = f_start, upd = 1, stay in DWELL.
REQ-028 DONE SHALL last one cycle with done = 1, then go to IDLE; fword/pword SHALL hold their last values.
REQ-029 abort SHALL force IDLE in the next cycle from any state, with no done and no upd; outputs hold.
REQ-030 abort and start in the same IDLE cycle: abort wins; the sweep does not start.
REQ-031 A cfg handshake during a sweep SHALL NOT occur (cfg_ready = 0); shadow values SHALL stay constant while busy.

Reset
REQ-032 On rst_n = 0 at a clock edge: state = IDLE; fword = 0, pword = 0, upd = 0, busy = 0, done = 0; cfg_ready = 1 in the following cycle; cfg_loaded = 0.
REQ-033 Reset mid-sweep SHALL abandon the sweep with no done pulse; start after reset without a new cfg SHALL be ignored.

Verification
REQ-034 Up sweep: start = 100, stop = 130, step = 10, dwell = 3, one-shot -> fword 100,110,120,130 each 3 cycles, 4 upd pulses, done 1 cycle after 130's final cycle, busy low next cycle.
REQ-035 Clamp and down: 100->130 step 25 -> 100,125,130; 130->100 step 20 -> 130,110,100.
REQ-036 Overflow: start 0xFFFFFFF0, stop 0xFFFFFFFF, step 0x20 -> 0xFFFFFFF0 then 0xFFFFFFFF, then done; never 0x10.
REQ-037 Continuous: 0->20 step 10 dwell 1 -> 0,10,20,0,10,... with no done; abort during 10 -> IDLE next cycle, fword stays 10, no done.
REQ-038 dwell = 0 behaves as dwell = 1; start before any cfg is ignored; rst_n low mid-sweep -> all outputs 0 next cycle, cfg_ready = 1 the cycle after.
REQ-039 abort + start in the same IDLE cycle -> busy stays 0.
